// File: rtl/pipeline_muldiv_ctrl.sv
// pipeline_muldiv_ctrl: iterative multiply/divide unit with HI/LO registers.
// Computes MULT/MULTU as a 32-step radix-2 shift-add and DIV/DIVU as a
// 32-step restoring shift-subtract, both sharing one adder/subtractor.
// Total latency from the accepting edge to o_done is 35 cycles.
//
// Configuration macro: PIPELINE_MULDIV_DIV_EN
//   defined   -> DIV/DIVU supported
//   undefined -> divider absent, starts with i_op[1]=1 ignored, o_div_zero=0
//
// Ports:
//   i_clk, i_rst      clock, asynchronous active-high reset
//   i_start, i_op     start request; 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   i_data_A/B        rs / rt operands
//   i_flush           abort the current operation (returns to IDLE)
//   i_hilo_we/wdata   MTHI (bit1) / MTLO (bit0) write, ignored while busy
//   o_busy, o_done    operation in progress / one-cycle completion pulse
//   o_div_zero        one-cycle pulse with o_done when the divisor was 0
//   o_hi, o_lo        HI / LO registers
module pipeline_muldiv_ctrl (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [1:0]  i_op,
  input  logic [31:0] i_data_A,
  input  logic [31:0] i_data_B,
  input  logic        i_flush,
  input  logic [1:0]  i_hilo_we,
  input  logic [31:0] i_hilo_wdata,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_div_zero,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo
);

  localparam int unsigned W = 32;

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_CALC, S_FIX, S_DONE} state_t;

  state_t         state;
  logic [4:0]     cnt;
  logic [1:0]     op_q;
  logic [W-1:0]   a_q;      // raw dividend kept for the divide-by-zero HI value
  logic [W-1:0]   b_q;      // raw operand B, replaced by its magnitude in SETUP
  logic [W-1:0]   acc_hi;   // product high half / partial remainder
  logic [W-1:0]   acc_lo;   // multiplier bits / dividend bits -> quotient
  logic           neg_q;

`ifdef PIPELINE_MULDIV_DIV_EN
  logic           is_div;
  logic           neg_r;
  logic           dz_q;
  logic           div_zero_q;
  assign is_div     = op_q[1];
  assign o_div_zero = div_zero_q;
`else
  assign o_div_zero = 1'b0;
`endif

  logic           signed_op;
  logic           accept_c;
  logic [W-1:0]   mag_a_c;
  logic [W-1:0]   mag_b_c;
  logic [W:0]     add_a;
  logic [W:0]     add_b;
  logic           add_ci;
  logic [W+1:0]   sum;
  logic [2*W-1:0] step_c;
  logic [2*W-1:0] prod_fix;
  logic [W-1:0]   fix_hi;
  logic [W-1:0]   fix_lo;

  assign signed_op = ~op_q[0];

`ifdef PIPELINE_MULDIV_DIV_EN
  assign accept_c = i_start && !i_flush && (state == S_IDLE || state == S_DONE);
`else
  assign accept_c = i_start && !i_flush && !i_op[1] && (state == S_IDLE || state == S_DONE);
  logic unused_bits;
  assign unused_bits = ^{op_q[1], sum[W+1]};
`endif

  // Operand magnitudes for signed ops
  assign mag_a_c = (signed_op && a_q[W-1]) ? (W'(0) - a_q) : a_q;
  assign mag_b_c = (signed_op && b_q[W-1]) ? (W'(0) - b_q) : b_q;

  // Shared adder: add for multiply, subtract (a + ~b + 1) for divide
  always_comb begin
    add_a  = {1'b0, acc_hi};
    add_b  = acc_lo[0] ? {1'b0, b_q} : '0;
    add_ci = 1'b0;
`ifdef PIPELINE_MULDIV_DIV_EN
    if (is_div) begin
      add_a  = {acc_hi, acc_lo[W-1]};
      add_b  = ~{1'b0, b_q};
      add_ci = 1'b1;
    end
`endif
    sum = (W+2)'(add_a) + (W+2)'(add_b) + (W+2)'(add_ci);
  end

  // One iteration; for divide sum[W+1] is the "no borrow" bit
  always_comb begin
    step_c = {sum[W:0], acc_lo[W-1:1]};
`ifdef PIPELINE_MULDIV_DIV_EN
    if (is_div) begin
      step_c = {(sum[W+1] ? sum[W-1:0] : {acc_hi[W-2:0], acc_lo[W-1]}),
                acc_lo[W-2:0], sum[W+1]};
    end
`endif
  end

  // Sign correction of the magnitude result
  always_comb begin
    prod_fix = neg_q ? ((2*W)'(0) - {acc_hi, acc_lo}) : {acc_hi, acc_lo};
    fix_hi   = prod_fix[2*W-1:W];
    fix_lo   = prod_fix[W-1:0];
`ifdef PIPELINE_MULDIV_DIV_EN
    if (is_div) begin
      if (dz_q) begin
        fix_hi = a_q;
        fix_lo = '1;
      end else begin
        fix_lo = neg_q ? (W'(0) - acc_lo) : acc_lo;
        fix_hi = neg_r ? (W'(0) - acc_hi) : acc_hi;
      end
    end
`endif
  end

  // Control FSM, datapath registers and HI/LO
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      neg_q  <= 1'b0;
      o_hi   <= '0;
      o_lo   <= '0;
      o_busy <= 1'b0;
      o_done <= 1'b0;
`ifdef PIPELINE_MULDIV_DIV_EN
      neg_r      <= 1'b0;
      dz_q       <= 1'b0;
      div_zero_q <= 1'b0;
`endif
    end else begin
      o_done <= 1'b0;
`ifdef PIPELINE_MULDIV_DIV_EN
      div_zero_q <= 1'b0;
`endif
      if (!o_busy && i_hilo_we[1]) o_hi <= i_hilo_wdata;
      if (!o_busy && i_hilo_we[0]) o_lo <= i_hilo_wdata;

      if (i_flush) begin
        state  <= S_IDLE;
        o_busy <= 1'b0;
      end else begin
        case (state)
          S_IDLE, S_DONE: begin
            state <= S_IDLE;
            if (accept_c) begin
              state  <= S_SETUP;
              o_busy <= 1'b1;
              op_q   <= i_op;
              a_q    <= i_data_A;
              b_q    <= i_data_B;
            end
          end
          S_SETUP: begin
            acc_hi <= '0;
            acc_lo <= mag_a_c;
            b_q    <= mag_b_c;
            neg_q  <= signed_op & (a_q[W-1] ^ b_q[W-1]);
            cnt    <= '0;
            state  <= S_CALC;
`ifdef PIPELINE_MULDIV_DIV_EN
            neg_r  <= signed_op & a_q[W-1];
            dz_q   <= (b_q == '0);
`endif
          end
          S_CALC: begin
            {acc_hi, acc_lo} <= step_c;
            cnt <= cnt + 5'd1;
            if (cnt == 5'd31) state <= S_FIX;
          end
          S_FIX: begin
            o_hi   <= fix_hi;
            o_lo   <= fix_lo;
            o_done <= 1'b1;
            o_busy <= 1'b0;
            state  <= S_DONE;
`ifdef PIPELINE_MULDIV_DIV_EN
            div_zero_q <= is_div & dz_q;
`endif
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pipeline_muldiv_ctrl.sv
// Self-checking bench for pipeline_muldiv_ctrl: directed steps with a
// scoreboard queue of expected HI/LO/div-zero results.
module tb_pipeline_muldiv_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] data_a;
  logic [31:0] data_b;
  logic        flush;
  logic [1:0]  hilo_we;
  logic [31:0] hilo_wdata;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  pipeline_muldiv_ctrl dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_op(op),
    .i_data_A(data_a), .i_data_B(data_b), .i_flush(flush),
    .i_hilo_we(hilo_we), .i_hilo_wdata(hilo_wdata),
    .o_busy(busy), .o_done(done), .o_div_zero(div_zero),
    .o_hi(hi), .o_lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference result, independent of the iterative datapath
  function automatic exp_t model(input logic [1:0] mop, input logic [31:0] a, input logic [31:0] b);
    exp_t r;
    logic signed [63:0] sa64, sb64, sp;
    logic [63:0] ua64, ub64, up;
    logic signed [31:0] sa, sbv;
    r.dz = 1'b0;
    sa64 = $signed(a); sb64 = $signed(b);
    ua64 = {32'd0, a}; ub64 = {32'd0, b};
    sa = a; sbv = b;
    case (mop)
      2'b00: begin sp = sa64 * sb64; r.hi = sp[63:32]; r.lo = sp[31:0]; end
      2'b01: begin up = ua64 * ub64; r.hi = up[63:32]; r.lo = up[31:0]; end
      default: begin
        if (b == 32'd0) begin
          r.hi = a; r.lo = 32'hFFFFFFFF; r.dz = 1'b1;
        end else if (mop == 2'b10 && a == 32'h80000000 && b == 32'hFFFFFFFF) begin
          r.hi = 32'd0; r.lo = 32'h80000000;
        end else if (mop == 2'b10) begin
          r.lo = sa / sbv; r.hi = sa % sbv;
        end else begin
          r.lo = a / b; r.hi = a % b;
        end
      end
    endcase
    return r;
  endfunction

  // Drive a start for one edge; returns in cycle 1 of the operation
  task automatic issue(input logic [1:0] mop, input logic [31:0] a, input logic [31:0] b);
    op = mop; data_a = a; data_b = b; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Wait for o_done (bounded), check latency and pop/compare the scoreboard
  task automatic finish(input string tag, input int cyc0);
    int   cyc;
    exp_t e;
    cyc = cyc0;
    while (!done && cyc < 60) begin
      tick();
      cyc++;
    end
    check({tag, "_latency"}, 64'(cyc), 64'd35);
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 64'(sb.size()), 64'd1);
    end else begin
      e = sb.pop_front();
      check({tag, "_hi"}, 64'(hi), 64'(e.hi));
      check({tag, "_lo"}, 64'(lo), 64'(e.lo));
      check({tag, "_dz"}, 64'(div_zero), 64'(e.dz));
      exp_hi = e.hi; exp_lo = e.lo;
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] mop, input logic [31:0] a, input logic [31:0] b);
    sb.push_back(model(mop, a, b));
    issue(mop, a, b);
    finish(tag, 1);
  endtask

  initial begin
    exp_t e;
    logic saw_done;
    rst = 1'b1; start = 1'b0; op = '0; data_a = '0; data_b = '0;
    flush = 1'b0; hilo_we = '0; hilo_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_dz", 64'(div_zero), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    rst = 1'b0;
    tick();

    // MULT -2 * 3 with cycle-by-cycle busy profile
    e.hi = 32'hFFFFFFFF; e.lo = 32'hFFFFFFFA; e.dz = 1'b0;
    sb.push_back(e);
    issue(2'b00, 32'hFFFFFFFE, 32'd3);
    for (int c = 1; c <= 34; c++) begin
      check($sformatf("mult_busy_c%0d", c), 64'({busy, done}), 64'b10);
      tick();
    end
    check("mult_c35_busy", 64'(busy), 64'd0);
    check("mult_c35_done", 64'(done), 64'd1);
    finish("mult_neg", 35);
    tick();
    check("mult_done_pulse", 64'(done), 64'd0);

    // MULTU max * max
    e.hi = 32'hFFFFFFFE; e.lo = 32'h00000001; e.dz = 1'b0;
    sb.push_back(e);
    issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
    finish("multu_max", 1);

    run_op("mult_minmin", 2'b00, 32'h80000000, 32'h80000000);
    run_op("mult_zero", 2'b00, 32'h00000000, 32'h87654321);
    for (int i = 0; i < 4; i++)
      run_op($sformatf("mul_rand%0d", i), 2'(i & 1), $urandom, $urandom);

`ifdef PIPELINE_MULDIV_DIV_EN
    e.hi = 32'hFFFFFFFF; e.lo = 32'hFFFFFFFD; e.dz = 1'b0;
    sb.push_back(e);
    issue(2'b10, 32'hFFFFFFF9, 32'd2);
    finish("div_neg7_2", 1);
    e.hi = 32'd7; e.lo = 32'hFFFFFFFF; e.dz = 1'b1;
    sb.push_back(e);
    issue(2'b11, 32'd7, 32'd0);
    finish("divu_by0", 1);
    tick();
    check("divu_by0_pulse", 64'(div_zero), 64'd0);
    e.hi = 32'd0; e.lo = 32'h80000000; e.dz = 1'b0;
    sb.push_back(e);
    issue(2'b10, 32'h80000000, 32'hFFFFFFFF);
    finish("div_wrap", 1);
    e.hi = 32'hFFFFFFFB; e.lo = 32'hFFFFFFFF; e.dz = 1'b1;
    sb.push_back(e);
    issue(2'b10, 32'hFFFFFFFB, 32'd0);
    finish("div_neg_by0", 1);
    run_op("div_7_neg2", 2'b10, 32'd7, 32'hFFFFFFFE);
    for (int i = 0; i < 4; i++)
      run_op($sformatf("div_rand%0d", i), 2'(2 + (i & 1)), $urandom, $urandom_range(1, 100000));
`else
    // Divide starts are ignored in this build
    op = 2'b10; data_a = 32'd100; data_b = 32'd5; start = 1'b1;
    tick();
    check("nodiv_busy", 64'(busy), 64'd0);
    op = 2'b11;
    tick();
    start = 1'b0;
    saw_done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      saw_done = saw_done | done | busy;
      tick();
    end
    check("nodiv_no_activity", 64'(saw_done), 64'd0);
    check("nodiv_hi", 64'(hi), 64'(exp_hi));
    check("nodiv_lo", 64'(lo), 64'(exp_lo));
`endif

    // Flush at cycle 10, then MTLO at cycle 12
    run_op("pre_flush", 2'b00, 32'd1234567, 32'hFFFFF000);
    issue(2'b00, 32'd11, 32'd13);
    repeat (9) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_busy_c11", 64'(busy), 64'd0);
    check("flush_hilo_c11", 64'({hi, lo}), 64'({exp_hi, exp_lo}));
    tick();
    hilo_we = 2'b01; hilo_wdata = 32'h1234;
    tick();
    hilo_we = 2'b00;
    exp_lo = 32'h1234;
    check("mtlo_lo", 64'(lo), 64'(exp_lo));
    check("mtlo_hi", 64'(hi), 64'(exp_hi));
    saw_done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      saw_done = saw_done | done;
      tick();
    end
    check("flush_no_done", 64'(saw_done), 64'd0);

    // MTHI while busy is dropped; a start while busy is ignored
    sb.push_back(model(2'b01, 32'd5, 32'd7));
    issue(2'b01, 32'd5, 32'd7);
    tick(); tick();
    hilo_we = 2'b10; hilo_wdata = 32'h5;
    op = 2'b00; data_a = 32'h7FFFFFFF; data_b = 32'h7FFFFFFF; start = 1'b1;
    tick();
    hilo_we = 2'b00; start = 1'b0;
    check("mthi_busy_hi", 64'(hi), 64'(exp_hi));
    finish("busy_ignore", 4);

    // Back-to-back start in DONE
    sb.push_back(model(2'b00, 32'hFFFF0000, 32'h00012345));
    issue(2'b00, 32'hFFFF0000, 32'h00012345);
    finish("b2b_second", 1);

    // MTHI/MTLO together with a start: write lands, result overwrites later
    sb.push_back(model(2'b01, 32'hDEADBEEF, 32'h10));
    hilo_we = 2'b11; hilo_wdata = 32'hAAAA5555;
    issue(2'b01, 32'hDEADBEEF, 32'h10);
    hilo_we = 2'b00;
    check("mt_start_hilo", 64'({hi, lo}), 64'({32'hAAAA5555, 32'hAAAA5555}));
    check("mt_start_busy", 64'(busy), 64'd1);
    finish("mt_start_op", 1);

    // Flush coinciding with DONE keeps the result
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_done_busy", 64'({busy, done}), 64'd0);
    check("flush_done_hilo", 64'({hi, lo}), 64'({exp_hi, exp_lo}));

    // Asynchronous reset mid-CALC, then a clean operation
    issue(2'b00, 32'd3, 32'd9);
    repeat (9) tick();
    #2 rst = 1'b1;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_hilo", 64'({hi, lo}), 64'd0);
    check("arst_done", 64'(done), 64'd0);
    #1 rst = 1'b0;
    tick();
    run_op("post_rst", 2'b00, 32'hFFFFFFF0, 32'h00000100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pipeline_muldiv_ctrl.md
PIPELINE_MULDIV_CTRL -- requirements
Module: pipeline_muldiv_ctrl

Interface
REQ-001 SHALL have ports: i_clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have ports: i_rst  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have ports: i_start  input  1  request new operation.
REQ-004 SHALL have ports: i_op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-005 SHALL have ports: i_data_A  input  32  multiplicand / dividend (rs).
REQ-006 SHALL have ports: i_data_B  input  32  multiplier / divisor (rt).
REQ-007 SHALL have ports: i_flush  input  1  abort current operation.
REQ-008 SHALL have ports: i_hilo_we  input  2  bit1 = MTHI write, bit0 = MTLO write.
REQ-009 SHALL have ports: i_hilo_wdata  input  32  MTHI/MTLO data.
REQ-010 SHALL have ports: o_busy  output  1  operation in progress; pipeline stalls MFHI/MFLO/new mul-div.
REQ-011 SHALL have ports: o_done  output  1  one-cycle completion pulse.
REQ-012 SHALL have ports: o_div_zero  output  1  one-cycle pulse with o_done when divisor was 0.
REQ-013 SHALL have ports: o_hi  output  32  HI register.
REQ-014 SHALL have ports: o_lo  output  32  LO register.
REQ-015 SHALL have no parameters; widths are fixed at 32.

Function
REQ-016 SHALL implement FSM states IDLE, SETUP, CALC, FIX, DONE.
REQ-017 SHALL accept i_start only in IDLE or DONE; accept edge moves to SETUP and latches i_op, i_data_A, i_data_B. i_start in SETUP/CALC/FIX SHALL be ignored.
REQ-018 SETUP, 1 cycle: for signed ops, take absolute values of the operands and record result signs (product/quotient = A[31]^B[31]; remainder = A[31]). Unsigned ops use the operands unmodified.
REQ-019 CALC, exactly 32 cycles, driven by a 5-bit iteration counter: multiply is radix-2 shift-add; divide is restoring shift-subtract. Each uses one shared 33-bit adder/subtractor.
REQ-020 FIX, 1 cycle: apply two's-complement sign correction.
REQ-021 DONE, 1 cycle: HI/LO updated, o_done=1; state then returns to IDLE unless a new start is accepted.
REQ-022 Latency: o_done SHALL be high exactly 35 cycles after the accepting edge (SETUP 1 + CALC 32 + FIX 1 + DONE).
REQ-023 o_busy SHALL be 1 in SETUP, CALC and FIX, and 0 in IDLE and DONE.
REQ-024 Multiply: {HI,LO} = 64-bit product; signed for MULT, unsigned for MULTU.
REQ-025 Divide: LO = quotient and HI = remainder, truncating toward zero.
REQ-026 Divide by zero: HI = dividend, LO = 32'hFFFFFFFF, o_div_zero=1 with o_done; no exception.
REQ-027 DIV 32'h80000000 / 32'hFFFFFFFF: LO = 32'h80000000, HI = 0 (wrap, no flag).
REQ-028 HI/LO SHALL change only at DONE entry or by an accepted MTHI/MTLO write.
REQ-029 i_hilo_we SHALL take effect only when o_busy=0, updating at the next edge.
REQ-030 MTHI/MTLO write SHALL be ignored while busy.
REQ-031 If i_hilo_we and i_start are asserted in the same cycle, the write applies and the start is accepted; the result later overwrites HI/LO.
REQ-032 i_flush SHALL force IDLE at the next edge from any state, take priority over i_start, and leave HI/LO unchanged. No o_done for the aborted operation.
REQ-033 A flush that coincides with DONE SHALL still have that cycle's HI/LO update and o_done take effect.

Reset
REQ-034 i_rst SHALL asynchronously force state IDLE, counter 0, HI=0, LO=0, o_busy=0, o_done=0, o_div_zero=0.
REQ-035 Reset mid-operation SHALL discard the operation; first accepted start after release SHALL behave as from power-up.

Configuration
REQ-036 Macro PIPELINE_MULDIV_DIV_EN defined: DIV/DIVU supported as above.
REQ-037 Macro PIPELINE_MULDIV_DIV_EN undefined: divider logic absent; i_start with i_op[1]=1 SHALL be ignored (no state change, no o_done, HI/LO unchanged); o_div_zero tied 0.

Verification
REQ-038 MULT A=32'hFFFFFFFE, B=3, start at edge 0 -> o_busy 1 on cycles 1..34; o_done at cycle 35; HI=32'hFFFFFFFF, LO=32'hFFFFFFFA.
REQ-039 MULTU A=B=32'hFFFFFFFF -> HI=32'hFFFFFFFE, LO=32'h00000001.
REQ-040 DIV A=-7, B=2 -> LO=32'hFFFFFFFD, HI=32'hFFFFFFFF; DIVU A=7, B=0 -> HI=7, LO=32'hFFFFFFFF, o_div_zero=1.
REQ-041 Start MULT, i_flush at cycle 10 -> IDLE at cycle 11, no o_done, prior HI/LO intact; MTLO 32'h1234 at cycle 12 -> LO=32'h1234.
REQ-042 MTHI 32'h5 while busy -> HI unchanged; back-to-back start during DONE -> second o_done exactly 35 cycles later.
REQ-043 i_rst asserted mid-CALC (no clock edge) -> outputs zero immediately; build without PIPELINE_MULDIV_DIV_EN -> DIV start ignored, o_busy stays 0.
